sky130_sram_1rw1r_param: RTL and testbench

Parametrised, synthesizable successor to the fixed 32x512 OpenRAM behavioural macro: one read/write port and one read-only port on a single clock, with configurable width, depth and write-mask granularity. Adds asynchronous active-low reset, a hardware memory-clear state machine, defined same-address collision behaviour and a collision flag. It sits between the Wishbone/logic-analyzer test harness and user logic as a drop-in storage block for the SRAM test project.

---
 rtl/sky130_sram_1rw1r_param_if.sv | 31 +++
 rtl/sky130_sram_1rw1r_param.sv | 134 +++++++++++++
 tb/tb_sky130_sram_1rw1r_param.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sky130_sram_1rw1r_param_if.sv
// Port bundle for sky130_sram_1rw1r_param: port 0 (read/write), port 1 (read-only) and status.
// The master drives requests; the slave (the SRAM) returns read data, busy and collision.
interface sky130_sram_1rw1r_param_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned WMASK_GRAN = 8
) ();
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;

  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  busy;
  logic                  collision;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout1, busy, collision
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout1, busy, collision
  );
endinterface

// File: rtl/sky130_sram_1rw1r_param.sv
// 1RW + 1R single-clock SRAM with byte-lane masking, post-reset clear FSM and collision flag.
// Define SRAM_OUT_REG_EN to add an output register stage (read latency 2).
module sky130_sram_1rw1r_param #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned WMASK_GRAN     = 8,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned BYPASS         = 1
) (
  input logic                      clk0,
  input logic                      rst0_n,
  sky130_sram_1rw1r_param_if.slave sram_if
);
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StReady = 1'b1;
  localparam logic [0:0] StReset = (CLEAR_ON_RESET != 0) ? StClear : StReady;

  if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
    $error("DATA_WIDTH must be a multiple of WMASK_GRAN");
  end

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_coll;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd1_data;

  logic [DATA_WIDTH-1:0] r_dout0;
  logic [DATA_WIDTH-1:0] r_dout1;
  logic                  r_coll;

  // Clear FSM: one word per cycle, leaves after writing the last address.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_state <= StReset;
      r_cnt   <= '0;
    end else if (r_state == StClear) begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
      if (&r_cnt) begin
        r_state <= StReady;
      end
    end
  end

  assign w_ready = (r_state == StReady);
  assign w_wr0   = w_ready & ~sram_if.csb0 & ~sram_if.web0;
  assign w_rd0   = w_ready & ~sram_if.csb0 &  sram_if.web0;
  assign w_rd1   = w_ready & ~sram_if.csb1;
  assign w_coll  = w_wr0 & w_rd1 & (sram_if.addr0 == sram_if.addr1);

  always_ff @(posedge clk0) begin
    if (r_state == StClear) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr0) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (sram_if.wmask0[i]) begin
          r_mem[sram_if.addr0][i*WMASK_GRAN +: WMASK_GRAN] <=
            sram_if.din0[i*WMASK_GRAN +: WMASK_GRAN];
        end
      end
    end
  end

  // Word as it will look after this cycle's write; unmasked lanes keep old data.
  always_comb begin
    w_merged = r_mem[sram_if.addr0];
    for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
      if (sram_if.wmask0[i]) begin
        w_merged[i*WMASK_GRAN +: WMASK_GRAN] = sram_if.din0[i*WMASK_GRAN +: WMASK_GRAN];
      end
    end
  end

  always_comb begin
    w_rd1_data = r_mem[sram_if.addr1];
    if ((BYPASS != 0) && w_coll) begin
      w_rd1_data = w_merged;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_dout0 <= '0;
      r_dout1 <= '0;
      r_coll  <= 1'b0;
    end else begin
      if (w_rd0) begin
        r_dout0 <= r_mem[sram_if.addr0];
      end
      if (w_rd1) begin
        r_dout1 <= w_rd1_data;
      end
      r_coll <= w_coll;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_dout0_p;
  logic [DATA_WIDTH-1:0] r_dout1_p;
  logic                  r_coll_p;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_dout0_p <= '0;
      r_dout1_p <= '0;
      r_coll_p  <= 1'b0;
    end else begin
      r_dout0_p <= r_dout0;
      r_dout1_p <= r_dout1;
      r_coll_p  <= r_coll;
    end
  end

  assign sram_if.dout0     = r_dout0_p;
  assign sram_if.dout1     = r_dout1_p;
  assign sram_if.collision = r_coll_p;
`else
  assign sram_if.dout0     = r_dout0;
  assign sram_if.dout1     = r_dout1;
  assign sram_if.collision = r_coll;
`endif

  assign sram_if.busy = ~w_ready;

endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Directed bench for sky130_sram_1rw1r_param (16 x 32, byte lanes, clear on reset, bypass on).
module tb_sky130_sram_1rw1r_param;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 4;
  localparam int unsigned GRAN = 8;
  localparam int unsigned BYP  = 1;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk0   = 1'b0;
  logic rst0_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_busy;
  logic coll_seen;

  sky130_sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_GRAN(GRAN)) u_if ();

  sky130_sram_1rw1r_param #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .WMASK_GRAN    (GRAN),
    .CLEAR_ON_RESET(1),
    .BYPASS        (BYP)
  ) u_dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .sram_if(u_if)
  );

  always #5 clk0 = ~clk0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    u_if.csb0   = 1'b1;
    u_if.web0   = 1'b1;
    u_if.csb1   = 1'b1;
    u_if.wmask0 = '0;
  endtask

  task automatic wait_lat();
    repeat (LAT - 1) tick();
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    u_if.csb0   = 1'b0;
    u_if.web0   = 1'b0;
    u_if.addr0  = a;
    u_if.din0   = d;
    u_if.wmask0 = m;
    tick();
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    u_if.csb0  = 1'b0;
    u_if.web0  = 1'b1;
    u_if.addr0 = a0;
    u_if.csb1  = 1'b0;
    u_if.addr1 = a1;
    tick();
    idle();
    wait_lat();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (u_if.busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    idle();
    u_if.addr0 = '0;
    u_if.addr1 = '0;
    u_if.din0  = '0;
    rst0_n = 1'b0;
    repeat (2) tick();
    check_eq("rst_busy", u_if.busy, 1);
    check_eq("rst_dout0", u_if.dout0, 0);
    check_eq("rst_dout1", u_if.dout1, 0);
    check_eq("rst_coll", u_if.collision, 0);

    // Hammer address 0 with a colliding write/read for the whole clear window.
    rst0_n      = 1'b1;
    u_if.csb0   = 1'b0;
    u_if.web0   = 1'b0;
    u_if.wmask0 = 4'hF;
    u_if.addr0  = '0;
    u_if.din0   = 32'hFFFF_FFFF;
    u_if.csb1   = 1'b0;
    u_if.addr1  = '0;
    n_busy      = 0;
    coll_seen   = 1'b0;
    while (u_if.busy && n_busy < 100) begin
      tick();
      n_busy++;
      if (u_if.collision) coll_seen = 1'b1;
    end
    idle();
    check_eq("clear_cycles", n_busy, 16);
    check_eq("busy_coll", coll_seen, 0);
    check_eq("busy_dout1", u_if.dout1, 0);

    for (int a = 0; a < 16; a++) begin
      rd(AW'(a), AW'(15 - a));
      check_eq("clr_rd0", u_if.dout0, 0);
      check_eq("clr_rd1", u_if.dout1, 0);
    end

    wr0(4'd5, 32'hDEAD_BEEF, 4'b1111);
    wr0(4'd5, 32'h1122_3344, 4'b0101);
    rd(4'd5, 4'd5);
    check_eq("mask_p0", u_if.dout0, 32'hDE22_BE44);
    check_eq("mask_p1", u_if.dout1, 32'hDE22_BE44);
    wr0(4'd5, 32'hFFFF_FFFF, 4'b0000);
    rd(4'd5, 4'd5);
    check_eq("mask0_nop", u_if.dout1, 32'hDE22_BE44);

    u_if.csb0   = 1'b0;
    u_if.web0   = 1'b0;
    u_if.addr0  = 4'd3;
    u_if.din0   = 32'hA5A5_A5A5;
    u_if.wmask0 = 4'hF;
    u_if.csb1   = 1'b0;
    u_if.addr1  = 4'd3;
    tick();
    idle();
    wait_lat();
    check_eq("coll_pulse", u_if.collision, 1);
    check_eq("coll_dout1", u_if.dout1, (BYP != 0) ? 32'hA5A5_A5A5 : 32'h0);
    tick();
    check_eq("coll_clear", u_if.collision, 0);

    u_if.csb0   = 1'b0;
    u_if.web0   = 1'b0;
    u_if.addr0  = 4'd3;
    u_if.din0   = 32'h1122_3344;
    u_if.wmask0 = 4'b0011;
    u_if.csb1   = 1'b0;
    u_if.addr1  = 4'd3;
    tick();
    idle();
    wait_lat();
    check_eq("coll2_pulse", u_if.collision, 1);
    check_eq("coll2_dout1", u_if.dout1, (BYP != 0) ? 32'hA5A5_3344 : 32'hA5A5_A5A5);
    rd(4'd3, 4'd3);
    check_eq("post_coll", u_if.dout0, 32'hA5A5_3344);

    u_if.csb0   = 1'b0;
    u_if.web0   = 1'b0;
    u_if.addr0  = 4'd4;
    u_if.din0   = 32'h0BAD_0BAD;
    u_if.wmask0 = 4'hF;
    u_if.csb1   = 1'b0;
    u_if.addr1  = 4'd3;
    tick();
    idle();
    wait_lat();
    check_eq("nocoll", u_if.collision, 0);

    // Write then read the same word on the very next edge.
    u_if.csb0   = 1'b0;
    u_if.web0   = 1'b0;
    u_if.addr0  = 4'd7;
    u_if.din0   = 32'hCAFE_F00D;
    u_if.wmask0 = 4'hF;
    tick();
    u_if.web0  = 1'b1;
    u_if.csb1  = 1'b0;
    u_if.addr1 = 4'd7;
    tick();
    idle();
    wait_lat();
    check_eq("b2b_p0", u_if.dout0, 32'hCAFE_F00D);
    check_eq("b2b_p1", u_if.dout1, 32'hCAFE_F00D);
    rd(4'd4, 4'd4);
    check_eq("wr4_p0", u_if.dout0, 32'h0BAD_0BAD);

    wr0(4'd2, 32'h1234_5678, 4'hF);
    rd(4'd2, 4'd2);
    check_eq("rd2_p0", u_if.dout0, 32'h1234_5678);
    check_eq("rd2_p1", u_if.dout1, 32'h1234_5678);
    u_if.addr0 = 4'd5;
    u_if.addr1 = 4'd5;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("hold_p0", u_if.dout0, 32'h1234_5678);
      check_eq("hold_p1", u_if.dout1, 32'h1234_5678);
    end
    wr0(4'd2, 32'h0, 4'hF);
    wait_lat();
    check_eq("wr_hold_p0", u_if.dout0, 32'h1234_5678);

    rst0_n = 1'b0;
    #1;
    check_eq("arst_dout0", u_if.dout0, 0);
    check_eq("arst_dout1", u_if.dout1, 0);
    check_eq("arst_busy", u_if.busy, 1);
    tick();
    rst0_n = 1'b1;
    repeat (7) tick();
    rst0_n = 1'b0;
    #1;
    check_eq("midclr_busy", u_if.busy, 1);
    tick();
    rst0_n = 1'b1;
    count_busy(n_busy);
    check_eq("reclear_cycles", n_busy, 16);
    rd(4'd5, 4'd7);
    check_eq("reclr_p0", u_if.dout0, 0);
    check_eq("reclr_p1", u_if.dout1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
